// File: rtl/xnor_cmp_sched.sv
// Shared slice-serial XNOR comparator with round-robin arbitration over NREQ requesters.
// Latency: accept in cycle T, RUN for S=WIDTH/SLICE cycles, rsp_valid first high in T+S+1.
// Backpressure: rsp_* held while rsp_ready=0; no request accepted until the response handshake.
module xnor_cmp_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*WIDTH-1:0]      req_a,
   input  logic [NREQ*WIDTH-1:0]      req_b,
   output logic [NREQ-1:0]            req_ready,
   output logic                       rsp_valid,
   output logic [$clog2(NREQ)-1:0]    rsp_id,
   output logic                       rsp_equal,
   output logic [$clog2(WIDTH+1)-1:0] rsp_match,
   input  logic                       rsp_ready
);

   localparam int S   = WIDTH / SLICE;
   localparam int IDW = $clog2(NREQ);
   localparam int MW  = $clog2(WIDTH + 1);
   localparam int PW  = $clog2(SLICE + 1);
   localparam int SCW = (S > 1) ? $clog2(S) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   gnt;
   logic             gnt_found;
   logic [IDW-1:0]   cur_id;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [SCW-1:0]   slice_cnt;
   logic [MW-1:0]    acc;
   logic [MW-1:0]    acc_next;
   logic [SLICE-1:0] xn;
   logic [PW-1:0]    pop;

   // Pick the first valid requester at or above ptr, wrapping around.
   always_comb begin
      gnt_found = 1'b0;
      gnt       = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_found && req_valid[(int'(ptr) + k) % NREQ]) begin
            gnt_found = 1'b1;
            gnt       = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   // One-hot accept strobe, only while idle and out of reset.
   always_comb begin
      req_ready = '0;
      if (!rst && state == IDLE && gnt_found) begin
         req_ready[gnt] = 1'b1;
      end
   end

   // XNOR of the current operand slice and its popcount added to the running total.
   always_comb begin
      xn  = ~(a_q[int'(slice_cnt)*SLICE +: SLICE] ^ b_q[int'(slice_cnt)*SLICE +: SLICE]);
      pop = '0;
      for (int i = 0; i < SLICE; i++) begin
         pop = pop + PW'(xn[i]);
      end
      acc_next = acc + MW'(pop);
   end

   // Scheduler FSM: accept, walk the slices, then hold the response until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         cur_id    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         slice_cnt <= '0;
         acc       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_equal <= 1'b0;
         rsp_match <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_found) begin
                  a_q       <= req_a[int'(gnt)*WIDTH +: WIDTH];
                  b_q       <= req_b[int'(gnt)*WIDTH +: WIDTH];
                  cur_id    <= gnt;
                  slice_cnt <= '0;
                  acc       <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               acc <= acc_next;
               if (slice_cnt == SCW'(S - 1)) begin
                  rsp_match <= acc_next;
                  rsp_equal <= (acc_next == MW'(WIDTH));
                  rsp_id    <= cur_id;
                  rsp_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  slice_cnt <= slice_cnt + SCW'(1);
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr       <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + IDW'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xnor_cmp_sched.sv
// Bench for xnor_cmp_sched: directed requests with a response scoreboard.
// Latency: n/a (testbench).
// Backpressure: stalls rsp_ready to check response hold and accept blocking.
module tb_xnor_cmp_sched;

   localparam int NREQ  = 4;
   localparam int WIDTH = 16;
   localparam int SLICE = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic [1:0]            rsp_id;
   logic                  rsp_equal;
   logic [4:0]            rsp_match;
   logic                  rsp_ready;

   xnor_cmp_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_equal (rsp_equal),
      .rsp_match (rsp_match),
      .rsp_ready (rsp_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int eq;
      int m;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_m;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   rise_cyc = 0;
   int   gnt_cnt[NREQ];
   logic prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int id, input int eq, input int m);
      exp_t e;
      e.id = id;
      e.eq = eq;
      e.m  = m;
      exp_q.push_back(e);
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
   endtask

   // Wait for a grant, check it is the expected one-hot, return its cycle.
   task automatic wait_accept(input int id, output int t);
      int n;
      logic [NREQ-1:0] want;
      want = '0;
      want[id] = 1'b1;
      n = 0;
      @(negedge clk);
      while (req_ready == '0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) chk("grant_timeout", 0, 1);
      chk("grant_onehot", int'(req_ready), int'(want));
      t = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: grant/response timing bookkeeping and scoreboard compare.
   always @(negedge clk) begin
      if (!rst) begin
         if (req_ready != '0) begin
            acc_cyc = cyc;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt_cnt[i]++;
         end
         if (rsp_valid && !prev_v) rise_cyc = cyc;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp_id", int'(rsp_id), -1);
            end else begin
               e_m = exp_q.pop_front();
               chk("rsp_id", int'(rsp_id), e_m.id);
               chk("rsp_equal", int'(rsp_equal), e_m.eq);
               chk("rsp_match", int'(rsp_match), e_m.m);
            end
         end
      end
      prev_v = rsp_valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t, tp, r, viol, g2;
      for (int i = 0; i < NREQ; i++) gnt_cnt[i] = 0;
      rst       = 1'b1;
      req_valid = 4'b0001;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_id", int'(rsp_id), 0);
      chk("rst_rsp_equal", int'(rsp_equal), 0);
      chk("rst_rsp_match", int'(rsp_match), 0);
      @(posedge clk);
      #1;
      req_valid = '0;
      rst       = 1'b0;
      @(posedge clk);
      #1;

      // Equal operands on requester 1, plus accept-to-valid latency.
      set_op(1, 16'hA5A5, 16'hA5A5);
      push(1, 1, 16);
      req_valid = 4'b0010;
      wait_accept(1, t);
      req_valid = '0;
      drain();
      chk("latency", rise_cyc - acc_cyc, 5);

      // Partial match and all-mismatch boundary.
      set_op(0, 16'h00FF, 16'h0F0F);
      push(0, 0, 8);
      req_valid = 4'b0001;
      wait_accept(0, t);
      req_valid = '0;
      drain();
      set_op(3, 16'h0000, 16'hFFFF);
      push(3, 0, 0);
      req_valid = 4'b1000;
      wait_accept(3, t);
      req_valid = '0;
      drain();

      // Round robin with all four requesters held valid.
      set_op(0, 16'h0000, 16'h0000);
      set_op(1, 16'h1111, 16'h0000);
      set_op(2, 16'h0007, 16'h0000);
      set_op(3, 16'h3333, 16'h0000);
      push(0, 1, 16);
      push(1, 0, 12);
      push(2, 0, 13);
      push(3, 0, 8);
      push(0, 1, 16);
      req_valid = 4'b1111;
      tp = 0;
      for (int k = 0; k < 5; k++) begin
         wait_accept(k % 4, t);
         if (k > 0) chk("rr_spacing", t - tp, 6);
         tp = t;
      end
      req_valid = '0;
      drain();

      // Backpressure with requester 2 pending.
      set_op(1, 16'hFF00, 16'hFF00);
      push(1, 1, 16);
      req_valid = 4'b0010;
      wait_accept(1, t);
      rsp_ready = 1'b0;
      set_op(2, 16'h00F0, 16'h0000);
      push(2, 0, 12);
      req_valid = 4'b0100;
      r = 0;
      @(negedge clk);
      while (!rsp_valid && r < 20) begin
         @(negedge clk);
         r++;
      end
      if (!rsp_valid) chk("stall_rsp_timeout", 0, 1);
      r = cyc;
      for (int j = 0; j < 3; j++) begin
         chk("stall_rsp_valid", int'(rsp_valid), 1);
         chk("stall_rsp_id", int'(rsp_id), 1);
         chk("stall_rsp_equal", int'(rsp_equal), 1);
         chk("stall_rsp_match", int'(rsp_match), 16);
         chk("stall_req_ready", int'(req_ready), 0);
         if (j < 2) @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      wait_accept(2, t);
      chk("accept_after_handshake", t - r, 4);
      req_valid = '0;
      drain();

      // Reset while requester 3 is in RUN.
      set_op(3, 16'h0F0F, 16'h0F0F);
      req_valid = 4'b1000;
      wait_accept(3, t);
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      viol = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (rsp_valid) viol++;
      end
      chk("no_rsp_after_rst", viol, 0);
      @(posedge clk);
      #1;
      set_op(0, 16'h1234, 16'h1234);
      push(0, 1, 16);
      req_valid = 4'b1001;
      wait_accept(0, t);
      req_valid = '0;
      drain();

      // Requester 2 raises and drops valid while the FSM is busy.
      g2 = gnt_cnt[2];
      set_op(1, 16'hAAAA, 16'h5555);
      push(1, 0, 0);
      req_valid = 4'b0010;
      wait_accept(1, t);
      req_valid = '0;
      @(posedge clk);
      #1;
      req_valid = 4'b0100;
      @(posedge clk);
      #1;
      req_valid = '0;
      drain();
      repeat (8) @(posedge clk);
      chk("late_drop_no_grant", gnt_cnt[2] - g2, 0);
      chk("late_drop_idle", int'(rsp_valid), 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
